imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes NWORDS of them to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the last word.
module imem_loader #(
   parameter int ADDR_W = 4,
   parameter int NWORDS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] wa,
   output logic [31:0]       wd,
   output logic              busy,
   output logic              done,
   output logic              cpu_rst_n,
   output logic              err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, FIN} state_t;
   logic [7:0] sum_q, sum_d;
   logic       err_q, err_d;
`else
   typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;
`endif
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NWORDS - 1);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [31:0]       wd_q, wd_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic              done_q, done_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   always_comb begin
      state_d  = state_q;
      wa_d     = wa_q;
      wd_d     = wd_q;
      bcnt_d   = bcnt_q;
      done_d   = done_q;
      in_ready = 1'b0;
      we       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d = RECV;
            wa_d    = '0;
            bcnt_d  = '0;
            done_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
            err_d   = 1'b0;
`endif
         end
         RECV: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wd_d[{bcnt_q, 3'b000} +: 8] = in_data;
               bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d  = sum_q + in_data;
`endif
               if (bcnt_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            we = 1'b1;
            if (wa_q < LAST) begin
               wa_d    = wa_q + 1'b1;
               state_d = RECV;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = FIN;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            in_ready = 1'b1;
            if (in_valid) begin
               err_d   = in_data != sum_q;
               state_d = FIN;
            end
         end
`endif
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // registered so the CPU stays held for the first cycle out of reset
      cpu_rst_n_d = state_d == IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wa_q        <= '0;
         wd_q        <= '0;
         bcnt_q      <= '0;
         done_q      <= 1'b0;
         cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wa_q        <= wa_d;
         wd_q        <= wd_d;
         bcnt_q      <= bcnt_d;
         done_q      <= done_d;
         cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
         err_q       <= err_d;
`endif
      end
   end
   assign wa        = wa_q;
   assign wd        = wd_q;
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign cpu_rst_n = cpu_rst_n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif
endmodule
